tsensor_sched: RTL and testbench
================================

TSENSOR_SCHED -- requirements
Module: tsensor_sched

Interface
REQ-001 Parameter EN_WIDTH, default 4: number of cycles ts_en is held high per conversion; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 64: maximum number of WAIT cycles before a conversion is aborted; legal range 2..65535.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 Port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port i_start, input, 1 bit: one-shot conversion request, sampled every cycle.
REQ-006 Port i_periodic_en, input, 1 bit: enables automatic periodic requests.
REQ-007 Port i_period, input, 16 bits: period between automatic requests, in cycles.
REQ-008 Port ts_en, output, 1 bit: drives the sensor en input.
REQ-009 Port ts_valid, input, 1 bit: sensor o_valid.
REQ-010 Port ts_data, input, 16 bits: sensor o_data.
REQ-011 Port o_valid, output, 1 bit: one-cycle pulse when o_data is updated.
REQ-012 Port o_data, output, 16 bits: last captured temperature code.
REQ-013 Port o_busy, output, 1 bit: high in every state except IDLE.
REQ-014 Port o_timeout, output, 1 bit: one-cycle pulse when a conversion is aborted.

Function
REQ-015 The block SHALL implement a four-state FSM (IDLE, PULSE, WAIT, DONE) and SHALL use a single pending-request flag.
REQ-016 The pending flag SHALL be set in any cycle in which i_start=1 or the period timer expires; simultaneous or repeated requests SHALL merge into one pending request, so at most one request is ever outstanding.
REQ-017 IDLE behaviour: when pending=1, the next state SHALL be PULSE and pending SHALL clear in the same cycle; otherwise the FSM stays in IDLE.
REQ-018 PULSE behaviour: ts_en SHALL be 1 for exactly EN_WIDTH consecutive cycles, after which the FSM moves to WAIT.
REQ-019 WAIT behaviour:
  - ts_en SHALL be 0.
  - A wait counter SHALL start at 0 on WAIT entry and increment every cycle.
  - If ts_valid=1, ts_data SHALL be captured into o_data and the FSM moves to DONE.
  - Else, if the counter equals TIMEOUT-1, o_timeout SHALL pulse for that cycle, o_data is unchanged, and the FSM moves to IDLE.
REQ-020 If ts_valid=1 in the same cycle the counter reaches TIMEOUT-1, the capture SHALL take priority and o_timeout SHALL stay 0.
REQ-021 DONE behaviour: o_valid SHALL be 1 for exactly one cycle (the cycle after capture), after which the FSM moves to IDLE.
REQ-022 ts_valid SHALL be ignored in IDLE, PULSE and DONE.
REQ-023 Request latency: ts_en SHALL rise on the cycle after a request is sampled while the FSM is in IDLE.
REQ-024 A request arriving in PULSE, WAIT or DONE SHALL set pending, and that request SHALL be serviced immediately after the FSM returns to IDLE.
REQ-025 Period timer behaviour:
  - A 16-bit counter SHALL run while i_periodic_en=1 and i_period!=0.
  - On reaching i_period-1 it SHALL set pending and wrap to 0.
  - When i_periodic_en=0 or i_period=0 it SHALL be held at 0 and issue no requests.
  - The counter SHALL keep running regardless of FSM state.
REQ-026 A change of i_period SHALL take effect at the next compare; if the counter is already at or above the new i_period-1, it SHALL wrap at 16'hFFFF (no immediate request).
REQ-027 o_data SHALL hold its value between captures; o_valid and o_timeout SHALL never both be 1 in the same cycle.

Reset
REQ-028 While rstn=0 at a rising edge of clk, the block SHALL reset: FSM=IDLE, pending=0, all counters=0, ts_en=0, o_valid=0, o_timeout=0, o_busy=0, o_data=16'h0000.
REQ-029 Reset asserted mid-conversion SHALL abort the conversion with no o_valid or o_timeout pulse; a ts_valid arriving after reset SHALL be ignored (the FSM is then in IDLE).

Verification
REQ-030 Single start (EN_WIDTH=4; sensor model returns 16'h0032 with ts_valid 20 cycles after ts_en falls) -> ts_en high 4 cycles, o_busy high throughout, o_data=16'h0032 with a single o_valid pulse, then IDLE.
REQ-031 Timeout (TIMEOUT=64, ts_valid tied 0) -> o_timeout pulses exactly 64 cycles after ts_en falls, o_data unchanged, o_valid never 1.
REQ-032 Periodic (i_period=200, i_periodic_en=1, conversion shorter than 200 cycles) -> ts_en rising edges exactly 200 cycles apart over 5 conversions.
REQ-033 Merge (i_start pulsed 3 times during WAIT, coincident with a period expiry) -> exactly one extra conversion follows the current one.
REQ-034 Boundary: ts_valid on the counter=TIMEOUT-1 cycle -> capture and o_valid, no o_timeout; i_period=0 with i_periodic_en=1 -> no conversions.
REQ-035 Reset: rstn=0 for 1 cycle during WAIT -> all outputs at reset values the next cycle; a late ts_valid is ignored; a subsequent i_start runs normally.

Source files
------------

// File: rtl/tsensor_sched.sv
// Temperature-sensor conversion scheduler: merges one-shot and periodic requests into one
// pending flag, then sequences the sensor enable pulse, result wait/timeout and hand-off.
module tsensor_sched #(
  parameter int unsigned EN_WIDTH = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_start,
  input  logic        i_periodic_en,
  input  logic [15:0] i_period,
  output logic        ts_en,
  input  logic        ts_valid,
  input  logic [15:0] ts_data,
  output logic        o_valid,
  output logic [15:0] o_data,
  output logic        o_busy,
  output logic        o_timeout
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPulse = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [7:0]  EnLast   = 8'(EN_WIDTH - 1);
  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        pending_q, pending_d;
  logic [7:0]  en_cnt_q, en_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] per_cnt_q, per_cnt_d;
  logic [15:0] data_q, data_d;
  logic        per_run, per_expire, req;

  // Free-running period timer; a shrinking period simply lets it wrap through 16'hFFFF.
  always_comb begin
    per_run    = i_periodic_en && (i_period != 16'd0);
    per_expire = per_run && (per_cnt_q == i_period - 16'd1);
    if (!per_run || per_expire) begin
      per_cnt_d = 16'd0;
    end else begin
      per_cnt_d = per_cnt_q + 16'd1;
    end
  end

  assign req = i_start | per_expire;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | req;
    en_cnt_d   = 8'd0;
    wait_cnt_d = 16'd0;
    data_d     = data_q;
    unique case (state_q)
      StIdle: begin
        // A request seen in IDLE is consumed at once, giving one-cycle start latency.
        pending_d = 1'b0;
        if (pending_q || req) begin
          state_d = StPulse;
        end
      end
      StPulse: begin
        if (en_cnt_q == EnLast) begin
          state_d = StWait;
        end else begin
          en_cnt_d = en_cnt_q + 8'd1;
        end
      end
      StWait: begin
        if (ts_valid) begin
          data_d  = ts_data;
          state_d = StDone;
        end else if (wait_cnt_q == WaitLast) begin
          state_d = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      en_cnt_q   <= 8'd0;
      wait_cnt_q <= 16'd0;
      per_cnt_q  <= 16'd0;
      data_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      en_cnt_q   <= en_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      per_cnt_q  <= per_cnt_d;
      data_q     <= data_d;
    end
  end

  // Pulses are masked while reset is asserted so an aborted conversion reports nothing.
  assign ts_en     = (state_q == StPulse);
  assign o_busy    = (state_q != StIdle);
  assign o_valid   = rstn && (state_q == StDone);
  assign o_timeout = rstn && (state_q == StWait) && !ts_valid && (wait_cnt_q == WaitLast);
  assign o_data    = data_q;

endmodule

// File: tb/tb_tsensor_sched.sv
// Self-checking bench for tsensor_sched: directed scenarios plus a randomized run against
// an age-based reference model of a conversion.
module tb_tsensor_sched;

  localparam int EW = 4;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rstn, i_start, i_periodic_en, ts_valid;
  logic [15:0] i_period, ts_data;
  logic        ts_en, o_valid, o_busy, o_timeout;
  logic [15:0] o_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tsensor_sched #(
    .EN_WIDTH(EW),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (i_start),
    .i_periodic_en(i_periodic_en),
    .i_period     (i_period),
    .ts_en        (ts_en),
    .ts_valid     (ts_valid),
    .ts_data      (ts_data),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout)
  );

  // Reference model: a conversion is tracked by its age (cycles since ts_en rose).
  logic        m_active, m_pend;
  int          m_age, m_cap;
  logic [15:0] m_per, m_data;
  logic        m_en, m_wait, m_done, m_cap_now, m_tmo, m_expire, m_req;

  always_comb begin
    m_en      = m_active && (m_age < EW);
    m_wait    = m_active && (m_age >= EW) && (m_cap < 0);
    m_done    = m_active && (m_cap >= 0);
    m_cap_now = m_wait && ts_valid;
    m_tmo     = rstn && m_wait && !ts_valid && ((m_age - EW) == TO - 1);
    m_expire  = i_periodic_en && (i_period != 16'd0) && (m_per == i_period - 16'd1);
    m_req     = i_start || m_expire;
  end

  always @(posedge clk) begin
    if (!rstn) begin
      m_active <= 1'b0;
      m_pend   <= 1'b0;
      m_age    <= 0;
      m_cap    <= -1;
      m_per    <= 16'd0;
      m_data   <= 16'd0;
    end else begin
      if (!i_periodic_en || i_period == 16'd0 || m_expire) m_per <= 16'd0;
      else m_per <= m_per + 16'd1;
      if (!m_active) begin
        if (m_pend || m_req) begin
          m_active <= 1'b1;
          m_age    <= 0;
          m_cap    <= -1;
          m_pend   <= 1'b0;
        end
      end else begin
        m_pend <= m_pend || m_req;
        if (m_cap_now) begin
          m_data <= ts_data;
          m_cap  <= m_age;
          m_age  <= m_age + 1;
        end else if (m_tmo || m_done) begin
          m_active <= 1'b0;
        end else begin
          m_age <= m_age + 1;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ts_en !== 1'b0) $display("FAIL reset_ts_en got %b want 0", ts_en); else n_pass++;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid got %b want 0", o_valid); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_o_busy got %b want 0", o_busy); else n_pass++;
    n_checks++; if (o_timeout !== 1'b0) $display("FAIL reset_o_timeout got %b want 0", o_timeout); else n_pass++;
    n_checks++; if (o_data !== 16'h0000) $display("FAIL reset_o_data got %h want 0000", o_data); else n_pass++;
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_single();
    int start_c, rise_c = -1, last_en = -1, valid_c = -1;
    int en_cnt = 0, v_cnt = 0, t_cnt = 0, busy_bad = 0;
    next_cycle();
    i_start = 1'b1;
    start_c = cyc;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ts_en) begin
        en_cnt++;
        last_en = cyc;
        if (rise_c < 0) rise_c = cyc;
      end
      if (o_valid) begin
        v_cnt++;
        valid_c = cyc;
      end
      if (o_timeout) t_cnt++;
      if (rise_c >= 0 && (valid_c < 0 || valid_c == cyc) && !o_busy) busy_bad++;
      next_cycle();
      i_start  = 1'b0;
      ts_valid = (last_en >= 0) && (cyc - last_en == 21);
      ts_data  = ts_valid ? 16'h0032 : 16'($urandom);
    end
    ts_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (rise_c !== start_c + 1) $display("FAIL single_latency got %0d want %0d", rise_c, start_c + 1); else n_pass++;
    n_checks++; if (en_cnt !== EW) $display("FAIL single_en_width got %0d want %0d", en_cnt, EW); else n_pass++;
    n_checks++; if (v_cnt !== 1) $display("FAIL single_valid_count got %0d want 1", v_cnt); else n_pass++;
    n_checks++; if (valid_c !== last_en + 22) $display("FAIL single_valid_cycle got %0d want %0d", valid_c, last_en + 22); else n_pass++;
    n_checks++; if (t_cnt !== 0) $display("FAIL single_timeout_count got %0d want 0", t_cnt); else n_pass++;
    n_checks++; if (o_data !== 16'h0032) $display("FAIL single_data got %h want 0032", o_data); else n_pass++;
    n_checks++; if (busy_bad !== 0) $display("FAIL single_busy_gaps got %0d want 0", busy_bad); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL single_end_idle got %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_timeout();
    int start_c, last_en = -1, tmo_c = -1, en_cnt = 0, v_cnt = 0, t_cnt = 0;
    next_cycle();
    i_start  = 1'b1;
    start_c  = cyc;
    ts_valid = 1'b1;
    ts_data  = 16'hDEAD;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (ts_en) begin
        en_cnt++;
        last_en = cyc;
      end
      if (o_valid) v_cnt++;
      if (o_timeout) begin
        t_cnt++;
        tmo_c = cyc;
      end
      next_cycle();
      i_start  = 1'b0;
      // Spurious valids during IDLE/PULSE must be ignored.
      ts_valid = (cyc <= start_c + 3);
    end
    ts_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (en_cnt !== EW) $display("FAIL timeout_en_width got %0d want %0d", en_cnt, EW); else n_pass++;
    n_checks++; if (t_cnt !== 1) $display("FAIL timeout_count got %0d want 1", t_cnt); else n_pass++;
    n_checks++; if (tmo_c - last_en !== TO) $display("FAIL timeout_delay got %0d want %0d", tmo_c - last_en, TO); else n_pass++;
    n_checks++; if (v_cnt !== 0) $display("FAIL timeout_valid_count got %0d want 0", v_cnt); else n_pass++;
    n_checks++; if (o_data !== 16'h0032) $display("FAIL timeout_data_held got %h want 0032", o_data); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL timeout_end_idle got %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_periodic();
    int rises[5];
    int nr = 0, tail = 0, last_en = -1, v_cnt = 0, t_cnt = 0;
    logic prev_en = 1'b0;
    next_cycle();
    i_period      = 16'd200;
    i_periodic_en = 1'b1;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (ts_en) last_en = cyc;
      if (ts_en && !prev_en && nr < 5) begin
        rises[nr] = cyc;
        nr++;
      end
      prev_en = ts_en;
      if (o_valid) v_cnt++;
      if (o_timeout) t_cnt++;
      next_cycle();
      ts_valid = (last_en >= 0) && (cyc - last_en == 11);
      ts_data  = 16'($urandom);
      if (nr == 5) begin
        i_periodic_en = 1'b0;
        tail++;
      end
      if (tail > 40) break;
    end
    ts_valid = 1'b0;
    n_checks++; if (nr !== 5) $display("FAIL periodic_rises got %0d want 5", nr); else n_pass++;
    for (int i = 1; i < 5; i++) begin
      if (i < nr) begin
        n_checks++;
        if (rises[i] - rises[i-1] !== 200)
          $display("FAIL periodic_spacing_%0d got %0d want 200", i, rises[i] - rises[i-1]);
        else n_pass++;
      end
    end
    n_checks++; if (v_cnt !== 5) $display("FAIL periodic_valid_count got %0d want 5", v_cnt); else n_pass++;
    n_checks++; if (t_cnt !== 0) $display("FAIL periodic_timeout_count got %0d want 0", t_cnt); else n_pass++;
  endtask

  task automatic test_merge();
    int rises = 0, t_cnt = 0, v_cnt = 0, tmo1 = -1, rise2 = -1;
    logic prev_en = 1'b0;
    bit coincided = 1'b0;
    next_cycle();
    i_period      = 16'd30;
    i_periodic_en = 1'b1;
    for (int k = 0; k < 260; k++) begin
      @(negedge clk);
      if (ts_en && !prev_en) begin
        rises++;
        if (rises == 2) rise2 = cyc;
      end
      prev_en = ts_en;
      if (o_timeout) begin
        t_cnt++;
        if (tmo1 < 0) tmo1 = cyc;
      end
      if (o_valid) v_cnt++;
      next_cycle();
      i_start = 1'b0;
      if (coincided) i_periodic_en = 1'b0;
      // One start lands on the period expiry, two more later in the same WAIT.
      if (rises == 1 && m_wait && i_periodic_en && m_per == 16'd29) begin
        i_start   = 1'b1;
        coincided = 1'b1;
      end else if (rises == 1 && m_wait && ((m_age - EW) == 40 || (m_age - EW) == 50)) begin
        i_start = 1'b1;
      end
    end
    i_start       = 1'b0;
    i_periodic_en = 1'b0;
    n_checks++; if (rises !== 2) $display("FAIL merge_conversions got %0d want 2", rises); else n_pass++;
    n_checks++; if (t_cnt !== 2) $display("FAIL merge_timeouts got %0d want 2", t_cnt); else n_pass++;
    n_checks++; if (v_cnt !== 0) $display("FAIL merge_valids got %0d want 0", v_cnt); else n_pass++;
    n_checks++; if (rise2 !== tmo1 + 2) $display("FAIL merge_service_delay got %0d want %0d", rise2, tmo1 + 2); else n_pass++;
  endtask

  task automatic test_boundary();
    int last_en = -1, valid_c = -1, v_cnt = 0, t_cnt = 0, en_seen = 0, busy_seen = 0;
    logic [15:0] d;
    d = 16'($urandom) | 16'h8000;
    next_cycle();
    i_start = 1'b1;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (ts_en) last_en = cyc;
      if (o_valid) begin
        v_cnt++;
        valid_c = cyc;
      end
      if (o_timeout) t_cnt++;
      next_cycle();
      i_start  = 1'b0;
      ts_valid = (last_en >= 0) && (cyc - last_en == TO);
      ts_data  = ts_valid ? d : 16'($urandom);
    end
    ts_valid = 1'b0;
    n_checks++; if (t_cnt !== 0) $display("FAIL edge_timeout_count got %0d want 0", t_cnt); else n_pass++;
    n_checks++; if (v_cnt !== 1) $display("FAIL edge_valid_count got %0d want 1", v_cnt); else n_pass++;
    n_checks++; if (valid_c !== last_en + TO + 1) $display("FAIL edge_valid_cycle got %0d want %0d", valid_c, last_en + TO + 1); else n_pass++;
    n_checks++; if (o_data !== d) $display("FAIL edge_data got %h want %h", o_data, d); else n_pass++;
    i_period      = 16'd0;
    i_periodic_en = 1'b1;
    for (int k = 0; k < 400; k++) begin
      next_cycle();
      @(negedge clk);
      if (ts_en) en_seen++;
      if (o_busy) busy_seen++;
    end
    i_periodic_en = 1'b0;
    n_checks++; if (en_seen !== 0) $display("FAIL period0_en_cycles got %0d want 0", en_seen); else n_pass++;
    n_checks++; if (busy_seen !== 0) $display("FAIL period0_busy_cycles got %0d want 0", busy_seen); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int last_en = -1, v_cnt = 0;
    next_cycle();
    i_start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ts_en) last_en = cyc;
      next_cycle();
      i_start = 1'b0;
      if (last_en >= 0 && cyc - last_en == 11) begin
        rstn = 1'b0;
        break;
      end
    end
    @(negedge clk);
    n_checks++; if (o_valid !== 1'b0 || o_timeout !== 1'b0) $display("FAIL rstmid_pulse got %b%b want 00", o_valid, o_timeout); else n_pass++;
    next_cycle();
    rstn     = 1'b1;
    ts_valid = 1'b1;
    ts_data  = 16'hBEEF;
    @(negedge clk);
    n_checks++;
    if ({ts_en, o_valid, o_busy, o_timeout, o_data} !== 20'h0)
      $display("FAIL rstmid_outputs got %b%b%b%b %h want 0000 0000", ts_en, o_valid, o_busy, o_timeout, o_data);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      ts_valid = 1'b0;
      @(negedge clk);
      if (o_valid) v_cnt++;
    end
    n_checks++; if (v_cnt !== 0 || o_data !== 16'h0) $display("FAIL rstmid_late_valid got %0d/%h want 0/0000", v_cnt, o_data); else n_pass++;
    last_en = -1;
    next_cycle();
    i_start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ts_en) last_en = cyc;
      if (o_valid) v_cnt++;
      next_cycle();
      i_start  = 1'b0;
      ts_valid = (last_en >= 0) && (cyc - last_en == 6);
      ts_data  = 16'h1234;
    end
    ts_valid = 1'b0;
    n_checks++; if (v_cnt !== 1) $display("FAIL rstmid_rerun_valids got %0d want 1", v_cnt); else n_pass++;
    n_checks++; if (o_data !== 16'h1234) $display("FAIL rstmid_rerun_data got %h want 1234", o_data); else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      next_cycle();
      rstn    = ($urandom_range(0, 599) != 0);
      i_start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 149) == 0) begin
        i_periodic_en = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 5))
          0: i_period = 16'd0;
          1: i_period = 16'd1;
          2: i_period = 16'd7;
          3: i_period = 16'($urandom_range(20, 120));
          4: i_period = 16'd3;
          default: i_period = 16'($urandom_range(2, 300));
        endcase
      end
      ts_valid = ($urandom_range(0, 24) == 0);
      ts_data  = 16'($urandom);
      @(negedge clk);
      n_checks++; if (ts_en !== m_en) $display("FAIL rand_ts_en cyc %0d got %b want %b", cyc, ts_en, m_en); else n_pass++;
      n_checks++; if (o_busy !== m_active) $display("FAIL rand_busy cyc %0d got %b want %b", cyc, o_busy, m_active); else n_pass++;
      n_checks++; if (o_valid !== (m_done && rstn)) $display("FAIL rand_valid cyc %0d got %b want %b", cyc, o_valid, m_done && rstn); else n_pass++;
      n_checks++; if (o_timeout !== m_tmo) $display("FAIL rand_timeout cyc %0d got %b want %b", cyc, o_timeout, m_tmo); else n_pass++;
      n_checks++; if (o_data !== m_data) $display("FAIL rand_data cyc %0d got %h want %h", cyc, o_data, m_data); else n_pass++;
      if (n_checks - n_pass > 40) break;
    end
    rstn          = 1'b1;
    i_start       = 1'b0;
    i_periodic_en = 1'b0;
    ts_valid      = 1'b0;
  endtask

  initial begin
    rstn          = 1'b0;
    i_start       = 1'b0;
    i_periodic_en = 1'b0;
    i_period      = 16'd0;
    ts_valid      = 1'b0;
    ts_data       = 16'd0;
    test_reset();
    test_single();
    test_timeout();
    test_periodic();
    test_merge();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
